// File: rtl/mult_fu_bp.sv
// rtl/mult_fu_bp.sv - pipelined RISC-V multiply unit with per-stage backpressure
// Shift-and-add product spread over NUM_STAGE stages; each advance retires one multiplier chunk.
module mult_fu_bp #(
    parameter int XLEN          = 32,
    parameter int NUM_STAGE     = 4,
    parameter int ROB_ADDR_BITS = 5,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    input  logic [1:0]                     func_in,
    input  logic [XLEN-1:0]                rs1_value_in,
    input  logic [XLEN-1:0]                rs2_value_in,
    input  logic [ROB_ADDR_BITS-1:0]       rob_idx_in,
    input  logic [REG_ADDR_BITS-1:0]       dest_reg_in,
    output logic                           cp_valid_out,
    input  logic                           cp_ready_in,
    output logic [XLEN-1:0]                cp_value_out,
    output logic [ROB_ADDR_BITS-1:0]       cp_rob_idx_out,
    output logic [REG_ADDR_BITS-1:0]       cp_dest_reg_out,
    output logic [$clog2(NUM_STAGE+1)-1:0] inflight_cnt_out
);
    localparam int PW    = 2 * XLEN;
    localparam int CHUNK = PW / NUM_STAGE;
    localparam int CNTW  = $clog2(NUM_STAGE + 1);
    localparam logic [PW-1:0] CHUNK_MASK = {PW{1'b1}} >> (PW - CHUNK);

    localparam logic [1:0] FN_MUL    = 2'd0;
    localparam logic [1:0] FN_MULH   = 2'd1;
    localparam logic [1:0] FN_MULHU  = 2'd3;

    logic [NUM_STAGE-1:0]     valid_q;
    logic [NUM_STAGE-1:0]     valid_d;
    logic [NUM_STAGE-1:0]     adv;
    logic [1:0]               func_q   [NUM_STAGE];
    logic [ROB_ADDR_BITS-1:0] rob_q    [NUM_STAGE];
    logic [REG_ADDR_BITS-1:0] dest_q   [NUM_STAGE];
    logic [PW-1:0]            acc_q    [NUM_STAGE];
    logic [PW-1:0]            mcand_q  [NUM_STAGE];
    logic [PW-1:0]            mplier_q [NUM_STAGE];
    logic [PW-1:0]            acc_d    [NUM_STAGE];
    logic [PW-1:0]            mcand_d  [NUM_STAGE];
    logic [PW-1:0]            mplier_d [NUM_STAGE];
    logic [CNTW-1:0]          cnt_q;
    logic [CNTW-1:0]          cnt_d;
    logic                     full_run;
    logic                     accept;
    logic                     rs1_signed;
    logic                     rs2_signed;
    logic [PW-1:0]            rs1_ext;
    logic [PW-1:0]            rs2_ext;

    // Sign-extending both operands to 2*XLEN makes the modular product exact for every variant.
    assign rs1_signed = (func_in != FN_MULHU);
    assign rs2_signed = (func_in == FN_MUL) || (func_in == FN_MULH);
    assign rs1_ext    = {{XLEN{rs1_signed & rs1_value_in[XLEN-1]}}, rs1_value_in};
    assign rs2_ext    = {{XLEN{rs2_signed & rs2_value_in[XLEN-1]}}, rs2_value_in};

    function automatic logic [PW-1:0] partial(input logic [PW-1:0] acc,
                                              input logic [PW-1:0] mcand,
                                              input logic [PW-1:0] mplier);
        return acc + mcand * (mplier & CHUNK_MASK);
    endfunction

    always_comb begin
        acc_d[0]    = partial('0, rs1_ext, rs2_ext);
        mcand_d[0]  = rs1_ext << CHUNK;
        mplier_d[0] = rs2_ext >> CHUNK;
        for (int k = 1; k < NUM_STAGE; k++) begin
            acc_d[k]    = partial(acc_q[k-1], mcand_q[k-1], mplier_q[k-1]);
            mcand_d[k]  = mcand_q[k-1] << CHUNK;
            mplier_d[k] = mplier_q[k-1] >> CHUNK;
        end
    end

    // A stage may advance unless it and every stage downstream are full with complete stalled.
    always_comb begin
        full_run = 1'b1;
        adv      = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            full_run = full_run & valid_q[k];
            adv[k]   = cp_ready_in | ~full_run;
        end
    end

    always_comb begin
        valid_d    = '0;
        accept     = valid_in & adv[0] & ~squash_in;
        valid_d[0] = adv[0] ? accept : valid_q[0];
        for (int k = 1; k < NUM_STAGE; k++) begin
            valid_d[k] = adv[k] ? valid_q[k-1] : valid_q[k];
        end
        if (squash_in) begin
            valid_d = '0;
        end
        cnt_d = '0;
        for (int k = 0; k < NUM_STAGE; k++) begin
            cnt_d = cnt_d + CNTW'(valid_d[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                func_q[k]   <= '0;
                rob_q[k]    <= '0;
                dest_q[k]   <= '0;
                acc_q[k]    <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (adv[0]) begin
                func_q[0]   <= func_in;
                rob_q[0]    <= rob_idx_in;
                dest_q[0]   <= dest_reg_in;
                acc_q[0]    <= acc_d[0];
                mcand_q[0]  <= mcand_d[0];
                mplier_q[0] <= mplier_d[0];
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (adv[k]) begin
                    func_q[k]   <= func_q[k-1];
                    rob_q[k]    <= rob_q[k-1];
                    dest_q[k]   <= dest_q[k-1];
                    acc_q[k]    <= acc_d[k];
                    mcand_q[k]  <= mcand_d[k];
                    mplier_q[k] <= mplier_d[k];
                end
            end
        end
    end

    assign ready_out        = adv[0];
    assign cp_valid_out     = valid_q[NUM_STAGE-1];
    assign cp_value_out     = (func_q[NUM_STAGE-1] == FN_MUL) ? acc_q[NUM_STAGE-1][XLEN-1:0]
                                                              : acc_q[NUM_STAGE-1][PW-1:XLEN];
    assign cp_rob_idx_out   = rob_q[NUM_STAGE-1];
    assign cp_dest_reg_out  = dest_q[NUM_STAGE-1];
    assign inflight_cnt_out = cnt_q;

endmodule
